sub16_pipe: RTL and testbench

SUB16_PIPE -- requirements
Module: sub16_pipe

---
 rtl/sub16_pkg.sv | 20 ++
 rtl/sub4_bla.sv | 30 +++
 rtl/sub16_pipe.sv | 96 +++++++++
 tb/tb_sub16_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub16_pkg.sv
// Shared widths and the per-stage register layout for the sliced 16-bit subtractor pipeline.
package sub16_pkg;

    localparam int SLICE_W = 4;
    localparam int STAGES  = 4;
    localparam int DATA_W  = 16;

    // Operand remainders are shifted down one slice per stage, so the live slice is always at [SLICE_W-1:0].
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a_rem;
        logic [DATA_W-1:0] b_rem;
        logic [DATA_W-1:0] diff;
        logic              borrow;
        logic              eq;
        logic              a_sign;
        logic              b_sign;
    } stage_t;

endpackage

// File: rtl/sub4_bla.sv
// 4-bit combinational borrow-lookahead subtractor: D = A - B - Bin, with borrow-out and slice equality.
module sub4_bla (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin,
    output logic [3:0] D,
    output logic       Bout,
    output logic       Peq
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        // A borrow is generated where a=0,b=1 and passes through where a==b.
        g    = ~A & B;
        p    = ~(A ^ B);
        c[0] = Bin;
        c[1] = g[0] | (p[0] & Bin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Bin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Bin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Bin);
        D    = A ^ B ^ c[3:0];
        Bout = c[4];
        Peq  = &p;
    end

endmodule

// File: rtl/sub16_pipe.sv
// Four-stage pipelined 16-bit subtractor, one 4-bit slice per stage, with a global valid/ready stall.
module sub16_pipe #(
    parameter int SLICE_W = sub16_pkg::SLICE_W,
    parameter int STAGES  = sub16_pkg::STAGES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] Diff,
    output logic        Bout,
    output logic        Eq,
    output logic        Ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    import sub16_pkg::*;

    // Entry 0 holds captured operands; entry k+1 holds the state after slice k; the last entry drives the outputs.
    stage_t st_q [STAGES+1];
    stage_t st_d [STAGES+1];

    logic [SLICE_W-1:0] d_w   [STAGES];
    logic               bo_w  [STAGES];
    logic               peq_w [STAGES];
    logic               advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_slice
            sub4_bla u_bla (
                .A    (st_q[k].a_rem[SLICE_W-1:0]),
                .B    (st_q[k].b_rem[SLICE_W-1:0]),
                .Bin  (st_q[k].borrow),
                .D    (d_w[k]),
                .Bout (bo_w[k]),
                .Peq  (peq_w[k])
            );
        end
    endgenerate

    assign advance  = !st_q[STAGES].valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        st_d = st_q;
        if (advance) begin
            st_d[0].valid = in_valid;
            if (in_valid) begin
                st_d[0].a_rem  = A;
                st_d[0].b_rem  = B;
                st_d[0].diff   = '0;
                st_d[0].borrow = Bin;
                st_d[0].eq     = 1'b1;
                st_d[0].a_sign = A[DATA_W-1];
                st_d[0].b_sign = B[DATA_W-1];
            end
            // Payload only moves with a valid entry, so bubbles leave the outputs holding their last values.
            for (int unsigned i = 0; i < STAGES; i++) begin
                st_d[i+1].valid = st_q[i].valid;
                if (st_q[i].valid) begin
                    st_d[i+1].a_rem                      = st_q[i].a_rem >> SLICE_W;
                    st_d[i+1].b_rem                      = st_q[i].b_rem >> SLICE_W;
                    st_d[i+1].diff                       = st_q[i].diff;
                    st_d[i+1].diff[i*SLICE_W +: SLICE_W] = d_w[i];
                    st_d[i+1].borrow                     = bo_w[i];
                    st_d[i+1].eq                         = st_q[i].eq & peq_w[i];
                    st_d[i+1].a_sign                     = st_q[i].a_sign;
                    st_d[i+1].b_sign                     = st_q[i].b_sign;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i <= STAGES; i++) begin
                st_q[i] <= '0;
            end
        end else begin
            st_q <= st_d;
        end
    end

    assign out_valid = st_q[STAGES].valid;
    assign Diff      = st_q[STAGES].diff;
    assign Bout      = st_q[STAGES].borrow;
    assign Eq        = st_q[STAGES].eq;
    assign Ovf       = (st_q[STAGES].a_sign != st_q[STAGES].b_sign)
                     & (st_q[STAGES].diff[DATA_W-1] != st_q[STAGES].a_sign);

endmodule

// File: tb/tb_sub16_pipe.sv
// Self-checking bench for sub16_pipe: directed vectors, stall/back-to-back, mid-flight reset and random stream.
module tb_sub16_pipe;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        eq;
        logic        ovf;
    } res_t;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Diff;
    logic        Bout;
    logic        Eq;
    logic        Ovf;
    logic        out_valid;
    logic        out_ready;

    int unsigned n_pass;
    int unsigned n_total;
    res_t        exp_q[$];

    // Outputs as seen just before the edge that ends the current cycle.
    logic        p_valid;
    logic        p_inr;
    res_t        p_res;

    sub16_pipe #(.SLICE_W(4), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Eq        (Eq),
        .Ovf       (Ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        res_t        r;
        int unsigned ua;
        int unsigned ub;
        int          sa;
        int          sb;
        int          sd;
        logic [31:0] t;
        ua     = a;
        ub     = b;
        sa     = int'($signed(a));
        sb     = int'($signed(b));
        sd     = sa - sb - int'(bi);
        t      = ua - ub - 32'(bi);
        r.diff = t[15:0];
        r.bout = (ua < ub + 32'(bi));
        r.eq   = (a == b);
        r.ovf  = (sd > 32767) || (sd < -32768);
        return r;
    endfunction

    task automatic cycle(input logic r, input logic iv, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, input logic ordy, output logic fin, output logic fout);
        rst       = r;
        in_valid  = iv;
        A         = a;
        B         = b;
        Bin       = bi;
        out_ready = ordy;
        #2;
        fin     = iv && in_ready && !r;
        fout    = out_valid && out_ready && !r;
        p_valid = out_valid;
        p_inr   = in_ready;
        p_res   = '{diff: Diff, bout: Bout, eq: Eq, ovf: Ovf};
        if (fin) exp_q.push_back(model(a, b, bi));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic fi, fo;
        cycle(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, fi, fo);
        cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, fi, fo);
        exp_q.delete();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (Diff !== 16'h0000) $display("FAIL reset_diff got=%h exp=0000", Diff); else n_pass++;
        n_total++; if ({Bout, Eq, Ovf} !== 3'b000) $display("FAIL reset_flags got=%b%b%b exp=000", Bout, Eq, Ovf); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] va  [4] = '{16'h1234, 16'h0000, 16'h8000, 16'hABCD};
        logic [15:0] vb  [4] = '{16'h0234, 16'h0001, 16'h0001, 16'hABCD};
        logic        vbi [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        res_t        ve  [4] = '{'{16'h1000, 1'b0, 1'b0, 1'b0}, '{16'hFFFF, 1'b1, 1'b0, 1'b0},
                                 '{16'h7FFF, 1'b0, 1'b0, 1'b1}, '{16'hFFFF, 1'b1, 1'b1, 1'b0}};
        logic fi, fo;
        int unsigned lat;
        res_t got;
        for (int v = 0; v < 4; v++) begin
            cycle(1'b0, 1'b1, va[v], vb[v], vbi[v], 1'b1, fi, fo);
            n_total++; if (fi !== 1'b1) $display("FAIL dir%0d_accept got=%b exp=1", v, fi); else n_pass++;
            lat = 0;
            while (!out_valid && lat < 10) begin
                cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
                lat++;
            end
            n_total++; if (lat !== 4) $display("FAIL dir%0d_latency got=%0d exp=4", v, lat); else n_pass++;
            got = '{diff: Diff, bout: Bout, eq: Eq, ovf: Ovf};
            n_total++;
            if (got !== ve[v])
                $display("FAIL dir%0d_result got diff=%h bout=%b eq=%b ovf=%b exp diff=%h bout=%b eq=%b ovf=%b",
                         v, got.diff, got.bout, got.eq, got.ovf, ve[v].diff, ve[v].bout, ve[v].eq, ve[v].ovf);
            else n_pass++;
            cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [6];
        logic [15:0] tb [6];
        logic        tbi[6];
        logic fi, fo, held_v;
        res_t held, e;
        int unsigned sent, rx, stalls, c;
        for (int i = 0; i < 6; i++) begin
            ta[i] = 16'($urandom); tb[i] = 16'($urandom); tbi[i] = 1'($urandom);
        end
        sent = 0; rx = 0; stalls = 0; held_v = 1'b0; held = '0;
        for (c = 0; rx < 6 && c < 40; c++) begin
            cycle(1'b0, sent < 6, ta[sent % 6], tb[sent % 6], tbi[sent % 6], !(c >= 5 && c <= 7), fi, fo);
            if (held_v) begin
                n_total++;
                if (!p_valid || p_res !== held)
                    $display("FAIL b2b_hold c=%0d got v=%b diff=%h exp v=1 diff=%h", c, p_valid, p_res.diff, held.diff);
                else n_pass++;
            end
            held_v = p_valid && !out_ready;
            held   = p_res;
            if (held_v) begin
                stalls++;
                n_total++; if (p_inr !== 1'b0) $display("FAIL b2b_in_ready c=%0d got=%b exp=0", c, p_inr); else n_pass++;
            end
            if (fi) sent++;
            if (fo) begin
                e = exp_q.pop_front();
                rx++;
                n_total++;
                if (p_res !== e) $display("FAIL b2b_result%0d got diff=%h flags=%b%b%b exp diff=%h flags=%b%b%b",
                                          rx, p_res.diff, p_res.bout, p_res.eq, p_res.ovf, e.diff, e.bout, e.eq, e.ovf);
                else n_pass++;
            end
        end
        n_total++; if (stalls !== 3) $display("FAIL b2b_stall_cycles got=%0d exp=3", stalls); else n_pass++;
        n_total++; if (c !== 14) $display("FAIL b2b_cycles got=%0d exp=14", c); else n_pass++;
        n_total++; if (rx !== 6 || exp_q.size() != 0) $display("FAIL b2b_count got=%0d exp=6", rx); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic fi, fo;
        int unsigned stale, lat;
        res_t e, got;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, fi, fo);
        cycle(1'b1, 1'b1, 16'h5555, 16'h1111, 1'b0, 1'b1, fi, fo);
        exp_q.delete();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); else n_pass++;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
            if (p_valid) stale++;
        end
        n_total++; if (stale !== 0) $display("FAIL rstmid_stale got=%0d exp=0", stale); else n_pass++;
        cycle(1'b0, 1'b1, 16'h4321, 16'h1234, 1'b1, 1'b1, fi, fo);
        e = model(16'h4321, 16'h1234, 1'b1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
            lat++;
        end
        got = '{diff: Diff, bout: Bout, eq: Eq, ovf: Ovf};
        n_total++; if (lat !== 4) $display("FAIL rstmid_latency got=%0d exp=4", lat); else n_pass++;
        n_total++; if (got !== e) $display("FAIL rstmid_result got diff=%h exp diff=%h", got.diff, e.diff); else n_pass++;
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
        exp_q.delete();
    endtask

    task automatic test_random_stream();
        logic fi, fo, held_v, iv, ordy;
        logic [15:0] a, b;
        res_t held, e;
        int unsigned drain;
        held_v = 1'b0; held = '0;
        for (int c = 0; c < 300; c++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       begin a = 16'($urandom); b = a; end
                1:       begin a = 16'h8000 ^ 16'($urandom_range(0, 3)); b = 16'($urandom_range(0, 3)); end
                default: begin a = 16'($urandom); b = 16'($urandom); end
            endcase
            cycle(1'b0, iv, a, b, 1'($urandom), ordy, fi, fo);
            if (held_v) begin
                n_total++;
                if (!p_valid || p_res !== held) $display("FAIL rnd_hold c=%0d got diff=%h exp diff=%h", c, p_res.diff, held.diff);
                else n_pass++;
            end
            held_v = p_valid && !ordy;
            held   = p_res;
            if (fo) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL rnd_unexpected c=%0d got diff=%h exp none", c, p_res.diff);
                else begin
                    e = exp_q.pop_front();
                    if (p_res !== e) $display("FAIL rnd_result c=%0d got diff=%h flags=%b%b%b exp diff=%h flags=%b%b%b",
                                              c, p_res.diff, p_res.bout, p_res.eq, p_res.ovf, e.diff, e.bout, e.eq, e.ovf);
                    else n_pass++;
                end
            end
        end
        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, fi, fo);
            drain++;
            if (fo) begin
                e = exp_q.pop_front();
                n_total++;
                if (p_res !== e) $display("FAIL rnd_drain got diff=%h exp diff=%h", p_res.diff, e.diff); else n_pass++;
            end
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL rnd_drain_left got=%0d exp=0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
